// File: rtl/reorder_bank_steer_pkg.sv
// Shared types and sizing helpers for the reorder ingress steering stage.
package reorder_pkg;

  typedef enum logic [1:0] {FILL, SEALED, DRAIN} bank_state_t;

  localparam int unsigned DefaultDw = 18;
  localparam int unsigned DefaultAw = 7;

  function automatic int unsigned depth_of(int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic int unsigned cnt_width(int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/reorder_bank_steer_if.sv
// Upstream word stream plus both bank FIFO write ports of the reorder ingress stage.
interface reorder_bank_steer_if #(
  parameter int unsigned DW = 18,
  parameter int unsigned AW = 7
);
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] in_data;
  logic [AW:0]   in_seq;
  logic          push_a;
  logic          push_b;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;
  logic [AW-1:0] offset_a;
  logic [AW-1:0] offset_b;
  logic          full_a;
  logic          full_b;
  logic          empty_a;
  logic          empty_b;
  logic          dup_err;

  modport master (
    output in_vld, in_data, in_seq, full_a, full_b, empty_a, empty_b,
    input  in_rdy, push_a, push_b, data_a, data_b, offset_a, offset_b, dup_err
  );

  modport slave (
    input  in_vld, in_data, in_seq, full_a, full_b, empty_a, empty_b,
    output in_rdy, push_a, push_b, data_a, data_b, offset_a, offset_b, dup_err
  );
endinterface

// File: rtl/reorder_bank_steer_bank_ctl.sv
// One bank window: FILL/SEALED/DRAIN sequencing, offset bitmap, entry count and
// registered FIFO write port.
module reorder_bank_ctl
  import reorder_pkg::*;
#(
  parameter int unsigned DW = 18,
  parameter int unsigned AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] wr_off,
  input  logic          full,
  input  logic          empty,
  output logic          fill,
  output logic          push,
  output logic          dup,
  output logic [DW-1:0] data,
  output logic [AW-1:0] offset
);
  localparam int unsigned Depth = depth_of(AW);
  localparam int unsigned CntW  = cnt_width(AW);
  localparam logic [CntW-1:0] LastCnt = CntW'(Depth - 1);

  bank_state_t     state;
  logic [CntW-1:0] cnt;
  logic [Depth-1:0] bitmap;

  assign fill = (state == FILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FILL;
      cnt    <= '0;
      bitmap <= '0;
      push   <= 1'b0;
      dup    <= 1'b0;
      data   <= '0;
      offset <= '0;
    end else begin
      push <= 1'b0;
      dup  <= 1'b0;
      unique case (state)
        FILL: begin
          if (wr_en) begin
            if (bitmap[wr_off]) begin
              dup <= 1'b1;
            end else begin
              bitmap[wr_off] <= 1'b1;
              cnt            <= cnt + CntW'(1);
              push           <= 1'b1;
              data           <= wr_data;
              offset         <= wr_off;
              // Window is complete once every offset has been written once.
              if (cnt == LastCnt) state <= SEALED;
            end
          end
        end
        SEALED: begin
          if (full) state <= DRAIN;
        end
        DRAIN: begin
          if (empty && !full) begin
            state  <= FILL;
            cnt    <= '0;
            bitmap <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: rtl/reorder_bank_steer.sv
// Ingress steering: routes sequence-tagged words to bank A/B by the tag MSB.
module reorder_bank_steer
  import reorder_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned AW = DefaultAw
) (
  input logic                 clk,
  input logic                 rst,
  reorder_bank_steer_if.slave bus
);
  logic          sel;
  logic [AW-1:0] off;
  logic          fill_a;
  logic          fill_b;
  logic          dup_a;
  logic          dup_b;
  logic          accept;

  assign sel        = bus.in_seq[AW];
  assign off        = bus.in_seq[AW-1:0];
  assign bus.in_rdy = sel ? fill_b : fill_a;
  assign accept     = bus.in_vld && bus.in_rdy;
  assign bus.dup_err = dup_a | dup_b;

  reorder_bank_ctl #(
    .DW (DW),
    .AW (AW)
  ) u_bank_a (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept && !sel),
    .wr_data (bus.in_data),
    .wr_off  (off),
    .full    (bus.full_a),
    .empty   (bus.empty_a),
    .fill    (fill_a),
    .push    (bus.push_a),
    .dup     (dup_a),
    .data    (bus.data_a),
    .offset  (bus.offset_a)
  );

  reorder_bank_ctl #(
    .DW (DW),
    .AW (AW)
  ) u_bank_b (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept && sel),
    .wr_data (bus.in_data),
    .wr_off  (off),
    .full    (bus.full_b),
    .empty   (bus.empty_b),
    .fill    (fill_b),
    .push    (bus.push_b),
    .dup     (dup_b),
    .data    (bus.data_b),
    .offset  (bus.offset_b)
  );

endmodule

// File: doc/reorder_bank_steer.md
# reorder_bank_steer

Upstream ingress stage of the double-buffered reorder path. It accepts an out-of-order stream of sequence-tagged words and steers each word into one of two `reorder_fifo` banks (A/B), using the sequence MSB as bank select and the low bits as write offset. It counts entries per window, drops duplicate offsets, and back-pressures a bank's window until the downstream FIFO has filled and drained.

## Interface
- `DW`, 18, data width
- `AW`, 7, offset width; window depth `DEPTH = 2**AW`
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_vld`  in  1  upstream word valid
- `in_rdy`  out  1  ready for the word currently on `in_seq`
- `in_data`  in  DW  payload
- `in_seq`  in  AW+1  sequence tag; `[AW]` = bank (0=A, 1=B), `[AW-1:0]` = offset
- `push_a` / `push_b`  out  1  write strobe to bank FIFO
- `data_a` / `data_b`  out  DW  write data
- `offset_a` / `offset_b`  out  AW  write offset
- `full_a` / `full_b`  in  1  bank FIFO full (registered downstream)
- `empty_a` / `empty_b`  in  1  bank FIFO empty (registered downstream)
- `dup_err`  out  1  one-cycle pulse: duplicate offset dropped

## Operation
- Per bank: state machine, entry counter `cnt` (AW+1 bits), occupancy bitmap (DEPTH bits).
- States: FILL -> SEALED -> DRAIN -> FILL.
  - FILL: accepts words for this bank. When `cnt` reaches DEPTH, go to SEALED.
  - SEALED: waits for the bank's `full_x`=1, then goes to DRAIN.
  - DRAIN: waits for `empty_x`=1 and `full_x`=0, then goes to FILL. On that transition, `cnt` and the bitmap clear.
- `in_rdy` = selected bank (`in_seq[AW]`) is in FILL. It is combinational on `in_seq`. Upstream must hold `in_seq`/`in_data` stable while `in_vld`=1 and `in_rdy`=0.
- Accept = `in_vld && in_rdy`.
- On accept with offset bit clear: set the bit, increment `cnt`, and issue a push to that bank.
- On accept with offset bit already set: no push, no `cnt` change, and `dup_err` pulses.
- Only one word per cycle, so the two banks never push on the same cycle.
- Banks are independent. Bank B can fill while bank A drains.

## Timing
- Reset values:
  - States: FILL for both banks.
  - Counters and bitmaps: 0.
  - `push_a`, `push_b`, `dup_err`: 0.
  - `data_x`, `offset_x`: 0.
  - `in_rdy` = 1 in the first cycle after reset.
- Latency: accept in cycle N drives `push_x`, `data_x`, `offset_x` in cycle N+1, all registered. `dup_err` also asserts in N+1.
- `push_x` is high only in N+1. `data_x`/`offset_x` hold their last value otherwise.
- The last (DEPTH-th) unique accept in cycle N puts the bank in SEALED at N+1. `in_rdy` for that bank is 0 from N+1.
- SEALED->DRAIN is taken the cycle after `full_x` is sampled 1. DRAIN->FILL is taken the cycle after `empty_x`=1 and `full_x`=0 are sampled. `in_rdy` for that bank returns in that next cycle.
- `empty_x` seen while in SEALED is ignored, because the bank must first see full.
- `cnt` never exceeds DEPTH. Arithmetic is unsigned, AW+1 bits, with no wrap.
- Reset mid-window discards all state. Pending pushes are cancelled, with `push_x`=0 in the cycle after `rst` is sampled.

## Structure
- Package `reorder_pkg`:
  - `bank_state_t` enum {FILL, SEALED, DRAIN}.
  - Localparam helpers for DEPTH and count width.
- Sub-module `reorder_bank_ctl`, instantiated twice. It holds the per-bank FSM, `cnt` and bitmap, and the registered push/data/offset outputs.
- Top level holds the bank select, the `in_rdy` mux and the `dup_err` OR.

## Test plan
- AW=2, DEPTH=4. Send bank A offsets 3,1,0,2 with data 0xA3,0xA1,0xA0,0xA2. Expect `push_a` each following cycle with matching offset/data. After the 4th accept, `in_rdy` is 0 for seq[2]=0.
- Bank A offsets 1,1. The second accept gives no push and `dup_err`=1 for one cycle, and `cnt` stays at 1.
- Bank A sealed and `full_a` not yet asserted. Drive `empty_a`=1: the bank stays SEALED. Then `full_a`=1, then `full_a`=0 with `empty_a`=1: `in_rdy` for bank A returns 1 two cycles later.
- Bank A in DRAIN. Stream bank B offsets 0..3: all accepted and pushed to B only, with `push_a` held at 0.
- Assert `rst` after 2 accepts to A. Next cycle: `push_a`=0, `in_rdy`=1. Offsets 0..3 are then all accepted without `dup_err`.
- Back-to-back `in_vld` alternating bank A/B, 8 words. Expect exactly 4 pushes per bank, never both the same cycle.
